// File: rtl/tmds_video_tx_pkg.sv
// Shared definitions for the TMDS video transmitter: DVI control tokens,
// token selection and raster-size helpers.
package tmds_video_tx_pkg;

  localparam logic [9:0] TOKEN_00 = 10'b1101010100;
  localparam logic [9:0] TOKEN_01 = 10'b0010101011;
  localparam logic [9:0] TOKEN_10 = 10'b0101010100;
  localparam logic [9:0] TOKEN_11 = 10'b1010101011;

  typedef struct packed {
    logic active;
    logic hsync;
    logic vsync;
  } vid_ctrl_t;

  // ctrl = {c1, c0}
  function automatic logic [9:0] ctrl_token(input logic [1:0] ctrl);
    logic [9:0] tok;
    unique case (ctrl)
      2'b00:   tok = TOKEN_00;
      2'b01:   tok = TOKEN_01;
      2'b10:   tok = TOKEN_10;
      default: tok = TOKEN_11;
    endcase
    return tok;
  endfunction

  function automatic int unsigned h_total(input int unsigned active, input int unsigned fp,
                                          input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int unsigned v_total(input int unsigned active, input int unsigned fp,
                                          input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/tmds_video_tx_enc.sv
// DVI 1.0 TMDS channel encoder: transition minimisation, DC balancing with a
// running disparity counter, and control-token insertion during blanking.
module tmds_channel_enc
  import tmds_video_tx_pkg::*;
#(
  parameter logic [1:0] RST_CTRL = 2'b00
) (
  input  logic       pixclk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] data_i,
  input  logic [1:0] ctrl_i,
  input  logic       de_i,
  output logic [9:0] sym_o
);

  logic [3:0]        n1_data;
  logic [3:0]        n1_qm;
  logic              use_xnor;
  logic              acc;
  logic [8:0]        q_m;
  logic signed [4:0] bal;
  logic signed [4:0] cnt_q, cnt_d;
  logic [9:0]        sym_q, sym_d;

  always_comb begin
    n1_data = '0;
    for (int i = 0; i < 8; i++) n1_data = n1_data + 4'(data_i[i]);
    use_xnor = (n1_data > 4'd4) || ((n1_data == 4'd4) && !data_i[0]);

    acc  = data_i[0];
    q_m  = '0;
    q_m[0] = acc;
    for (int i = 1; i < 8; i++) begin
      acc    = use_xnor ? ~(acc ^ data_i[i]) : (acc ^ data_i[i]);
      q_m[i] = acc;
    end
    q_m[8] = ~use_xnor;

    n1_qm = '0;
    for (int i = 0; i < 8; i++) n1_qm = n1_qm + 4'(q_m[i]);
    // ones minus zeros of q_m[7:0]; wraps correctly for n1_qm == 8
    bal = $signed({n1_qm, 1'b0}) - 5'sd8;

    sym_d = sym_q;
    cnt_d = cnt_q;
    if (!de_i) begin
      sym_d = ctrl_token(ctrl_i);
      cnt_d = '0;
    end else if ((cnt_q == 5'sd0) || (n1_qm == 4'd4)) begin
      sym_d = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]};
      cnt_d = q_m[8] ? cnt_q + bal : cnt_q - bal;
    end else if (cnt_q[4] == bal[4]) begin
      sym_d = {1'b1, q_m[8], ~q_m[7:0]};
      cnt_d = cnt_q - bal + $signed({3'b000, q_m[8], 1'b0});
    end else begin
      sym_d = {1'b0, q_m[8], q_m[7:0]};
      cnt_d = cnt_q + bal - $signed({3'b000, ~q_m[8], 1'b0});
    end
  end

  always_ff @(posedge pixclk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      sym_q <= ctrl_token(RST_CTRL);
    end else if (en) begin
      cnt_q <= cnt_d;
      sym_q <= sym_d;
    end
  end

  assign sym_o = sym_q;

endmodule

// File: rtl/tmds_video_tx.sv
// Raster timing generator plus three TMDS channel encoders; sync/active are
// delayed PIX_LAT enabled cycles to line up with the externally fetched RGB.
module tmds_video_tx
  import tmds_video_tx_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned SYNC_POS = 1,
  parameter int unsigned PIX_LAT  = 1
) (
  input  logic        pixclk,
  input  logic        rst,
  input  logic        en,
  output logic [11:0] x,
  output logic [11:0] y,
  output logic        pix_req,
  output logic        frame_start,
  input  logic [7:0]  red,
  input  logic [7:0]  green,
  input  logic [7:0]  blue,
  output logic [9:0]  tmds_red,
  output logic [9:0]  tmds_green,
  output logic [9:0]  tmds_blue,
  output logic        de
);

  localparam int unsigned H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam logic [11:0] X_LAST  = 12'(H_TOTAL - 1);
  localparam logic [11:0] Y_LAST  = 12'(V_TOTAL - 1);
  localparam logic [11:0] X_ACT   = 12'(H_ACTIVE);
  localparam logic [11:0] Y_ACT   = 12'(V_ACTIVE);
  localparam logic [11:0] HS_BEG  = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END  = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] VS_BEG  = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END  = 12'(V_ACTIVE + V_FP + V_SYNC);
  // Blue's control levels while syncs are deasserted
  localparam logic [1:0]  IDLE_CTRL = (SYNC_POS != 0) ? 2'b00 : 2'b11;

  logic [11:0] x_q, x_d, y_q, y_d;
  logic        fs_q, fs_d;
  logic        de_q;
  vid_ctrl_t   ctrl_now;
  vid_ctrl_t   smp;
  vid_ctrl_t   pipe_q [PIX_LAT];
  logic        hs_lvl, vs_lvl;

  always_comb begin
    x_d = x_q + 12'd1;
    y_d = y_q;
    if (x_q == X_LAST) begin
      x_d = '0;
      y_d = (y_q == Y_LAST) ? '0 : y_q + 12'd1;
    end
    fs_d = (x_d == '0) && (y_d == '0);

    ctrl_now.active = (x_q < X_ACT) && (y_q < Y_ACT);
    ctrl_now.hsync  = (x_q >= HS_BEG) && (x_q < HS_END);
    ctrl_now.vsync  = (y_q >= VS_BEG) && (y_q < VS_END);
  end

  always_ff @(posedge pixclk or posedge rst) begin
    if (rst) begin
      x_q  <= '0;
      y_q  <= '0;
      fs_q <= 1'b0;
      de_q <= 1'b0;
      for (int i = 0; i < PIX_LAT; i++) pipe_q[i] <= '0;
    end else if (en) begin
      x_q  <= x_d;
      y_q  <= y_d;
      fs_q <= fs_d;
      de_q <= smp.active;
      pipe_q[0] <= ctrl_now;
      for (int i = 1; i < PIX_LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign smp    = pipe_q[PIX_LAT-1];
  assign hs_lvl = (SYNC_POS != 0) ? smp.hsync : ~smp.hsync;
  assign vs_lvl = (SYNC_POS != 0) ? smp.vsync : ~smp.vsync;

  tmds_channel_enc #(.RST_CTRL(2'b00)) u_enc_red (
    .pixclk (pixclk),
    .rst    (rst),
    .en     (en),
    .data_i (red),
    .ctrl_i (2'b00),
    .de_i   (smp.active),
    .sym_o  (tmds_red)
  );

  tmds_channel_enc #(.RST_CTRL(2'b00)) u_enc_green (
    .pixclk (pixclk),
    .rst    (rst),
    .en     (en),
    .data_i (green),
    .ctrl_i (2'b00),
    .de_i   (smp.active),
    .sym_o  (tmds_green)
  );

  tmds_channel_enc #(.RST_CTRL(IDLE_CTRL)) u_enc_blue (
    .pixclk (pixclk),
    .rst    (rst),
    .en     (en),
    .data_i (blue),
    .ctrl_i ({vs_lvl, hs_lvl}),
    .de_i   (smp.active),
    .sym_o  (tmds_blue)
  );

  assign x           = x_q;
  assign y           = y_q;
  assign pix_req     = ctrl_now.active;
  assign frame_start = fs_q;
  assign de          = de_q;

endmodule

// File: tb/tb_tmds_video_tx.sv
// Bench for tmds_video_tx: two instances on a small raster (PIX_LAT=1/SYNC_POS=1
// and PIX_LAT=3/SYNC_POS=0) checked every cycle against a DVI reference model.
module tb_tmds_video_tx;

  localparam int HA = 16, HF = 2, HS = 3, HB = 3;
  localparam int VA = 6,  VF = 1, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;

  localparam logic [9:0] T00 = 10'b1101010100;
  localparam logic [9:0] T01 = 10'b0010101011;
  localparam logic [9:0] T10 = 10'b0101010100;
  localparam logic [9:0] T11 = 10'b1010101011;

  typedef struct packed {
    logic [9:0] r;
    logic [9:0] g;
    logic [9:0] b;
    logic       de;
  } sym_t;

  typedef struct {
    logic [7:0] r, g, b;
    logic [9:0] er, eg, eb;
  } vec_t;

  logic       pixclk = 1'b0;
  logic       rst, en;
  logic [7:0] red, green, blue;

  logic [11:0] x_a, y_a, x_b, y_b;
  logic        pr_a, fs_a, de_a, pr_b, fs_b, de_b;
  logic [9:0]  tr_a, tg_a, tb_a, tr_b, tg_b, tb_b;
  logic [30:0] dout [2];
  logic [25:0] rout [2];

  int checks = 0;
  int errors = 0;

  sym_t sb0 [$];
  sym_t sb1 [$];
  sym_t exp_hold [2];
  logic rise [2];
  int   cr [2], cg [2], cb [2];
  int   mx, my;
  logic mfs;
  logic p_act [1:4], p_hs [1:4], p_vs [1:4];
  vec_t tbl [3];
  logic tbl_active = 1'b0;
  int   ncyc = 0;
  int   last_fs = -1;

  always #5 pixclk = ~pixclk;

  tmds_video_tx #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POS(1), .PIX_LAT(1)
  ) dut_a (
    .pixclk(pixclk), .rst(rst), .en(en), .x(x_a), .y(y_a), .pix_req(pr_a),
    .frame_start(fs_a), .red(red), .green(green), .blue(blue),
    .tmds_red(tr_a), .tmds_green(tg_a), .tmds_blue(tb_a), .de(de_a)
  );

  tmds_video_tx #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POS(0), .PIX_LAT(3)
  ) dut_b (
    .pixclk(pixclk), .rst(rst), .en(en), .x(x_b), .y(y_b), .pix_req(pr_b),
    .frame_start(fs_b), .red(red), .green(green), .blue(blue),
    .tmds_red(tr_b), .tmds_green(tg_b), .tmds_blue(tb_b), .de(de_b)
  );

  assign dout[0] = {tr_a, tg_a, tb_a, de_a};
  assign dout[1] = {tr_b, tg_b, tb_b, de_b};
  assign rout[0] = {x_a, y_a, pr_a, fs_a};
  assign rout[1] = {x_b, y_b, pr_b, fs_b};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // DVI 1.0 reference encoder
  task automatic enc(input logic [7:0] d, input logic act, input logic [1:0] c,
                     input int cin, output int cout, output logic [9:0] s);
    int n1, n1q, n0q;
    logic xn;
    logic [8:0] qm;
    if (!act) begin
      cout = 0;
      case (c)
        2'b00:   s = T00;
        2'b01:   s = T01;
        2'b10:   s = T10;
        default: s = T11;
      endcase
    end else begin
      n1 = $countones(d);
      xn = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
      qm = '0;
      qm[0] = d[0];
      for (int i = 1; i < 8; i++) qm[i] = xn ? (qm[i-1] ~^ d[i]) : (qm[i-1] ^ d[i]);
      qm[8] = !xn;
      n1q = $countones(qm[7:0]);
      n0q = 8 - n1q;
      if (cin == 0 || n1q == n0q) begin
        s = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
        cout = qm[8] ? cin + n1q - n0q : cin + n0q - n1q;
      end else if ((cin > 0 && n1q > n0q) || (cin < 0 && n0q > n1q)) begin
        s = {1'b1, qm[8], ~qm[7:0]};
        cout = cin + 2 * int'(qm[8]) + n0q - n1q;
      end else begin
        s = {1'b0, qm[8], qm[7:0]};
        cout = cin - 2 * int'(!qm[8]) + n1q - n0q;
      end
    end
  endtask

  task automatic model_reset();
    mx = 0;
    my = 0;
    mfs = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      p_act[k] = 1'b0;
      p_hs[k]  = 1'b0;
      p_vs[k]  = 1'b0;
    end
    for (int d = 0; d < 2; d++) begin
      cr[d] = 0;
      cg[d] = 0;
      cb[d] = 0;
      rise[d] = 1'b0;
    end
    exp_hold[0] = '{T00, T00, T00, 1'b0};
    exp_hold[1] = '{T00, T00, T11, 1'b0};
    sb0.delete();
    sb1.delete();
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_raster_a"}, {6'b0, rout[0]}, {6'b0, 24'b0, 1'b1, 1'b0});
    check({tag, "_raster_b"}, {6'b0, rout[1]}, {6'b0, 24'b0, 1'b1, 1'b0});
    check({tag, "_sym_a"}, {1'b0, dout[0]}, {1'b0, T00, T00, T00, 1'b0});
    check({tag, "_sym_b"}, {1'b0, dout[1]}, {1'b0, T00, T00, T11, 1'b0});
  endtask

  // Drive one cycle (called just after an edge), push expectations, then check after the edge.
  task automatic cycle(input logic en_v, input logic [7:0] r, input logic [7:0] g,
                       input logic [7:0] b);
    sym_t e;
    logic [9:0] sr, sg, sbl;
    en = en_v;
    red = r;
    green = g;
    blue = b;
    for (int d = 0; d < 2; d++) begin
      int lat;
      logic act, hl, vl;
      rise[d] = 1'b0;
      if (en_v) begin
        lat = (d == 0) ? 1 : 3;
        act = p_act[lat];
        hl  = (d == 0) ? p_hs[lat] : !p_hs[lat];
        vl  = (d == 0) ? p_vs[lat] : !p_vs[lat];
        enc(r, act, 2'b00, cr[d], cr[d], sr);
        enc(g, act, 2'b00, cg[d], cg[d], sg);
        enc(b, act, {vl, hl}, cb[d], cb[d], sbl);
        rise[d] = act && !exp_hold[d].de;
        exp_hold[d] = '{sr, sg, sbl, act};
      end
    end
    sb0.push_back(exp_hold[0]);
    sb1.push_back(exp_hold[1]);
    if (en_v) begin
      for (int k = 4; k > 1; k--) begin
        p_act[k] = p_act[k-1];
        p_hs[k]  = p_hs[k-1];
        p_vs[k]  = p_vs[k-1];
      end
      p_act[1] = (mx < HA) && (my < VA);
      p_hs[1]  = (mx >= HA + HF) && (mx < HA + HF + HS);
      p_vs[1]  = (my >= VA + VF) && (my < VA + VF + VS);
      if (mx == HT - 1) begin
        mx = 0;
        my = (my == VT - 1) ? 0 : my + 1;
      end else begin
        mx++;
      end
      mfs = (mx == 0) && (my == 0);
    end

    @(posedge pixclk);
    #1;
    for (int d = 0; d < 2; d++) begin
      if ((d == 0 && sb0.size() == 0) || (d == 1 && sb1.size() == 0)) begin
        checks++;
        errors++;
        $display("FAIL sb_empty dut %0d: got empty queue expected one entry", d);
      end else begin
        e = (d == 0) ? sb0.pop_front() : sb1.pop_front();
        check((d == 0) ? "sym_a" : "sym_b", {1'b0, dout[d]}, {1'b0, e});
        if (tbl_active && rise[d])
          check("first_sym", {2'b0, dout[d][30:1]},
                {2'b0, tbl[my % 3].er, tbl[my % 3].eg, tbl[my % 3].eb});
      end
      check((d == 0) ? "raster_a" : "raster_b", {6'b0, rout[d]},
            {6'b0, 12'(mx), 12'(my), (mx < HA) && (my < VA), mfs});
    end
    if (en_v) begin
      ncyc++;
      if (fs_a) begin
        if (last_fs >= 0) check("fs_period", ncyc - last_fs, HT * VT);
        last_fs = ncyc;
      end
    end
  endtask

  initial begin
    tbl[0] = '{8'h00, 8'hFF, 8'h01, 10'h100, 10'h200, 10'h1FF};
    tbl[1] = '{8'h10, 8'h0F, 8'hAA, 10'h1F0, 10'h105, 10'h233};
    tbl[2] = '{8'hAA, 8'h00, 8'hFF, 10'h233, 10'h100, 10'h200};

    rst = 1'b1;
    en = 1'b0;
    red = '0;
    green = '0;
    blue = '0;
    model_reset();
    repeat (3) @(posedge pixclk);
    #1;
    check_reset("por");
    rst = 1'b0;

    // Constant colour per line; the first symbol of each line starts from cnt = 0.
    tbl_active = 1'b1;
    for (int i = 0; i < VA * HT; i++) begin
      cycle(1'b1, tbl[my % 3].r, tbl[my % 3].g, tbl[my % 3].b);
      if (i == 0) check("first_x", {20'b0, x_a}, 32'd1);
    end
    tbl_active = 1'b0;

    for (int i = 0; i < (VT - VA) * HT + VT * HT; i++)
      cycle(1'b1, 8'($urandom()), 8'($urandom()), 8'($urandom()));

    for (int i = 0; i < 3 * VT * HT; i++)
      cycle(i % 3 == 0, 8'($urandom()), 8'($urandom()), 8'($urandom()));

    for (int i = 0; i < 50; i++)
      cycle(1'b0, 8'($urandom()), 8'($urandom()), 8'($urandom()));

    for (int i = 0; i < 2 * VT * HT && !(mx == 10 && my == 3); i++)
      cycle(1'b1, 8'($urandom()), 8'($urandom()), 8'($urandom()));

    // Asynchronous reset mid-line, checked before the next clock edge.
    #3;
    rst = 1'b1;
    #1;
    check_reset("async");
    model_reset();
    last_fs = -1;
    @(posedge pixclk);
    #1;
    check_reset("held");
    rst = 1'b0;
    for (int i = 0; i < VT * HT + 2 * HT; i++) begin
      cycle(1'b1, 8'($urandom()), 8'($urandom()), 8'($urandom()));
      if (i == 0) check("restart_x", {20'b0, x_b}, 32'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tmds_video_tx.md
TMDS_VIDEO_TX -- requirements
Module: tmds_video_tx

Interface
REQ-001 The block SHALL take parameter H_ACTIVE, default 640, active pixels per line.
REQ-002 The block SHALL take parameters H_FP/H_SYNC/H_BP, defaults 16/96/48, horizontal front porch/sync/back porch in pixels.
REQ-003 The block SHALL take parameter V_ACTIVE, default 480, active lines per frame.
REQ-004 The block SHALL take parameters V_FP/V_SYNC/V_BP, defaults 10/2/33, vertical porch/sync/porch in lines.
REQ-005 The block SHALL take parameter SYNC_POS, default 1: 1 = sync asserted high during the sync interval, 0 = asserted low.
REQ-006 The block SHALL take parameter PIX_LAT, default 1, range 1..4: cycles from coordinate output to RGB sampling.
REQ-007 Ports: pixclk  in  1  pixel clock, sole clock of the block.
REQ-008 Ports: rst  in  1  asynchronous, active-high reset.
REQ-009 Ports: en  in  1  clock enable; when low, all state holds.
REQ-010 Ports: x, y  out  12 each  current raster coordinate.
REQ-011 Ports: pix_req  out  1  high when (x,y) is inside the active area.
REQ-012 Ports: frame_start  out  1  one-cycle pulse at (0,0).
REQ-013 Ports: red, green, blue  in  8 each  pixel data for the coordinate issued PIX_LAT enabled cycles earlier.
REQ-014 Ports: tmds_red, tmds_green, tmds_blue  out  10 each  encoded symbols, LSB transmitted first.
REQ-015 Ports: de  out  1  data-enable aligned with the TMDS outputs.

Function
REQ-016 x SHALL count 0..H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP, and wrap to 0.
REQ-017 y SHALL increment when x wraps, count 0..V_TOTAL-1 (V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP), and wrap to 0.
REQ-018 hsync SHALL be active for H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC.
REQ-019 vsync SHALL be active for V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC.
REQ-020 The active level of hsync and vsync SHALL follow SYNC_POS.
REQ-021 pix_req SHALL equal (x < H_ACTIVE) && (y < V_ACTIVE), combinationally with x and y.
REQ-022 active, hsync and vsync SHALL be delayed PIX_LAT enabled cycles by a shift pipeline so they align with sampled RGB.
REQ-023 The TMDS outputs for a pixel SHALL be registered one enabled cycle after its RGB is sampled: total latency from coordinate to symbol is PIX_LAT+1.
REQ-024 de SHALL carry the same latency as the TMDS outputs.
REQ-025 Stage 1 of each channel SHALL minimise transitions per DVI 1.0: XNOR if ones>4, or ones==4 and d[0]==0; q_m[8] = ~XNOR.
REQ-026 Stage 2 SHALL DC-balance per DVI 1.0 using a 5-bit signed running disparity cnt.
REQ-027 Stage 2 inversion SHALL be: if cnt==0 or ones(q_m[7:0])==4, invert = ~q_m[8]; else invert when sign(cnt) equals sign(ones-zeros).
REQ-028 cnt SHALL be updated exactly per the DVI 1.0 formula, including the q_m[8] correction term.
REQ-029 When delayed active is low, cnt SHALL be forced to 0 and control tokens emitted: {c1,c0}=00:1101010100, 01:0010101011, 10:0101010100, 11:1010101011.
REQ-030 Blue SHALL use c0 = hsync and c1 = vsync; red and green SHALL use c = 00.
REQ-031 With en low, counters, pipelines, cnt and outputs SHALL hold; en affects no output combinationally except through held state.
REQ-032 When the last active pixel and the wrap at x = H_TOTAL-1 coincide, no extra symbol SHALL be emitted and the token SHALL follow immediately.

Reset
REQ-033 While rst is high: x=0, y=0, all pipeline stages inactive, cnt=0.
REQ-034 While rst is high: tmds_* SHALL be the token for their deasserted control levels.
REQ-035 While rst is high: de=0 and frame_start=0.
REQ-036 Assertion of rst mid-line or mid-frame SHALL take effect immediately, independent of pixclk.
REQ-037 After rst is released, the first enabled edge SHALL produce x=1; frame_start SHALL pulse at the next (0,0).

Structure
REQ-038 A shared package SHALL hold the four control-token constants, the token-select function, and the derived H_TOTAL/V_TOTAL helpers.
REQ-039 One sub-module, tmds_channel_enc (8-bit data, 2-bit control, de, en; owns cnt and its output register), SHALL be instantiated three times.

Verification
REQ-040 Default parameters, 2 frames: exactly 800 cycles per line and 420000 per frame; frame_start period = 420000; hsync high for x in 656..751; vsync high for y in 490..491.
REQ-041 red=green=blue=0x00 constant: each symbol SHALL be 0100000000/1111111111 alternating per the DVI reference model, cnt never outside ±8, and every line SHALL have net disparity 0 at de fall.
REQ-042 Random RGB vs. a DVI 1.0 golden encoder model for 10 lines: bit-exact match of all three channels at latency PIX_LAT+1, for PIX_LAT=1 and PIX_LAT=3.
REQ-043 SYNC_POS=0, blanking with vsync and hsync active: tmds_blue=1101010100 and red/green=1101010100; outside sync, blue=1010101011.
REQ-044 en toggled 1-of-3 cycles: outputs SHALL match the en=1 run decimated; with en held low for 50 cycles, all outputs SHALL remain constant.
REQ-045 rst pulsed at x=300, y=200 mid-frame: outputs SHALL be at reset values before the next pixclk edge; on release, the raster SHALL restart at 0,0 and cnt SHALL be 0.
